// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: sequencer state encoding and constant-width helpers
package rst_seq_pkg;
    typedef enum logic [2:0] {HOLD, RELEASE, WAIT_ACK, GAP, DONE, ASSERT} state_e;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction
endpackage

// File: rtl/rst_seq_ctrl_if.sv
// rst_seq_ctrl_if: request/ack inputs and sequenced reset outputs of the reset sequencer
interface rst_seq_ctrl_if #(parameter int NUM_DOMAINS = 3);
    logic                   sw_rst_req;
    logic [NUM_DOMAINS-1:0] domain_ack;
    logic [NUM_DOMAINS-1:0] domain_rst_n;
    logic                   seq_busy;
    logic                   seq_done;
    logic                   timeout_err;
    modport master (output sw_rst_req, domain_ack, input domain_rst_n, seq_busy, seq_done, timeout_err);
    modport slave  (input sw_rst_req, domain_ack, output domain_rst_n, seq_busy, seq_done, timeout_err);
endinterface

// File: rtl/rst_seq_cnt.sv
// rst_seq_cnt: saturating up-counter with clear and terminal-count flag against a loaded limit
module rst_seq_cnt #(parameter int W = 8) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic [W-1:0] last_i,
    output logic         tc_o
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr_i ? '0 : (inc_i && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    assign tc_o = (cnt_q == last_i);
endmodule

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: releases downstream domain resets one at a time, waiting for each ack,
// with a sticky ack-timeout flag and a software-requested replay from DONE.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int STEP_CYCLES = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    rst_seq_ctrl_if.slave bus
);
    localparam int CNT_W = clog2(max3(HOLD_CYCLES, STEP_CYCLES, ACK_TIMEOUT) + 1);
    localparam int IDX_W = (NUM_DOMAINS > 1) ? clog2(NUM_DOMAINS) : 1;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] rst_q, rst_d;
    logic                   busy_q, busy_d, done_q, done_d, terr_q, terr_d;
    logic                   cnt_inc, tc, ack_sel, last_dom;
    logic [CNT_W-1:0]       last_cnt;

    assign ack_sel  = bus.domain_ack[idx_q];
    assign last_dom = (idx_q == IDX_W'(NUM_DOMAINS - 1));
    assign last_cnt = (state_q == HOLD)     ? CNT_W'(HOLD_CYCLES - 1) :
                      (state_q == WAIT_ACK) ? CNT_W'(ACK_TIMEOUT - 1) : CNT_W'(STEP_CYCLES - 1);

    // The counter clears whenever a state is not actively counting, so every
    // counted state starts from zero.
    rst_seq_cnt #(.W(CNT_W)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (!cnt_inc),
        .inc_i  (cnt_inc),
        .last_i (last_cnt),
        .tc_o   (tc)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= HOLD;
            idx_q   <= '0;
            rst_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            terr_q  <= terr_d;
        end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_inc = 1'b0;
        case (state_q)
            HOLD:     if (tc) state_d = RELEASE; else cnt_inc = 1'b1;
            RELEASE:  state_d = WAIT_ACK;
            WAIT_ACK: if (ack_sel || tc) state_d = GAP; else cnt_inc = 1'b1;
            GAP:      if (tc) begin
                          state_d = last_dom ? DONE : RELEASE;
                          idx_d   = last_dom ? idx_q : idx_q + 1'b1;
                      end else cnt_inc = 1'b1;
            DONE:     if (bus.sw_rst_req) state_d = ASSERT;
            ASSERT:   begin
                          state_d = HOLD;
                          idx_d   = '0;
                      end
            default:  state_d = HOLD;
        endcase
    end

    // Outputs are registered from the current state, so each lags its state by one edge.
    always_comb begin
        rst_d  = (state_q == ASSERT) ? '0 : (state_q == DONE) ? '1 :
                 (state_q == RELEASE) ? rst_q | (NUM_DOMAINS'(1) << idx_q) : rst_q;
        busy_d = (state_q != DONE);
        done_d = (state_q == DONE);
        terr_d = (state_q == ASSERT) ? 1'b0 : (state_q == WAIT_ACK && !ack_sel && tc) ? 1'b1 : terr_q;
    end

    assign bus.domain_rst_n = rst_q;
    assign bus.seq_busy     = busy_q;
    assign bus.seq_done     = done_q;
    assign bus.timeout_err  = terr_q;
endmodule
